// File: rtl/fft_result_reader.sv
// Holds one FFT result set and serves it two ways: random CPU reads
// (1-cycle latency) and a ready/valid serial drain of every word.
module fft_result_reader #(
  parameter int WORDS     = 32,
  parameter int WORDWIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           capture_i,
  input  logic [WORDS*WORDWIDTH-1:0]     res_i,
  input  logic                           clr_i,
  input  logic                           en_i,
  input  logic [$clog2(WORDS)-1:0]       addr_i,
  output logic [31:0]                    data_o,
  output logic                           rd_valid_o,
  input  logic                           stream_start_i,
  output logic                           stream_valid_o,
  input  logic                           stream_ready_i,
  output logic [WORDWIDTH-1:0]           stream_data_o,
  output logic                           stream_last_o,
  output logic                           results_valid_o,
  output logic                           overrun_o
);

  // state  | meaning
  // IDLE   | no result set held
  // HOLD   | result set held, available for reads and streaming
  // STREAM | draining the held set, one word per accepted transfer

  localparam int AW = $clog2(WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, HOLD, STREAM} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [WORDWIDTH-1:0]  buf_q [WORDS];
  logic [WORDWIDTH-1:0]  buf_d [WORDS];
  logic                  results_valid_q, results_valid_d;
  logic                  overrun_q, overrun_d;
  logic [31:0]           data_q, data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  xfer;

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    buf_d           = buf_q;
    results_valid_d = results_valid_q;
    overrun_d       = overrun_q;
    rd_valid_d      = en_i;
    data_d          = data_q;
    xfer            = (state_q == STREAM) && stream_ready_i;

    // Reads sample the buffer before any same-cycle capture lands.
    if (en_i) begin
      data_d = 32'($signed(buf_q[addr_i]));
    end

    if (clr_i) begin
      state_d         = IDLE;
      idx_d           = '0;
      results_valid_d = 1'b0;
      overrun_d       = 1'b0;
    end else begin
      if (xfer) begin
        if (idx_q == LAST_IDX) begin
          state_d = HOLD;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      if (capture_i) begin
        if (state_q == STREAM) begin
          overrun_d = 1'b1;
        end else begin
          for (int k = 0; k < WORDS; k++) begin
            buf_d[k] = res_i[k*WORDWIDTH +: WORDWIDTH];
          end
          state_d         = HOLD;
          results_valid_d = 1'b1;
        end
      end else if (stream_start_i && state_q == HOLD) begin
        state_d = STREAM;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      results_valid_q <= 1'b0;
      overrun_q       <= 1'b0;
      data_q          <= '0;
      rd_valid_q      <= 1'b0;
      for (int k = 0; k < WORDS; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      results_valid_q <= results_valid_d;
      overrun_q       <= overrun_d;
      data_q          <= data_d;
      rd_valid_q      <= rd_valid_d;
      buf_q           <= buf_d;
    end
  end

  assign data_o          = data_q;
  assign rd_valid_o      = rd_valid_q;
  assign results_valid_o = results_valid_q;
  assign overrun_o       = overrun_q;
  assign stream_valid_o  = (state_q == STREAM);
  assign stream_data_o   = (state_q == STREAM) ? buf_q[idx_q] : '0;
  assign stream_last_o   = (state_q == STREAM) && (idx_q == LAST_IDX);

endmodule

// File: doc/fft_result_reader.md
FFT_RESULT_READER -- requirements
Module: fft_result_reader

Interface
REQ-001 SHALL have parameter WORDS, default 32, meaning the number of result words held.
REQ-002 SHALL have parameter WORDWIDTH, default 16, meaning the width of each signed result word.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port capture_i  input  1  one-cycle pulse; the accelerator's results on res_i are valid.
REQ-006 SHALL have port res_i  input  WORDS*WORDWIDTH  parallel results; word k occupies bits [k*WORDWIDTH +: WORDWIDTH].
REQ-007 SHALL have port clr_i  input  1  discard results, clear flags, return to IDLE.
REQ-008 SHALL have port en_i  input  1  CPU read request.
REQ-009 SHALL have port addr_i  input  $clog2(WORDS)  CPU read word index.
REQ-010 SHALL have port data_o  output  32  CPU read data, the result word sign-extended to 32 bits.
REQ-011 SHALL have port rd_valid_o  output  1  data_o valid; a one-cycle pulse.
REQ-012 SHALL have port stream_start_i  input  1  request a serial drain of all words.
REQ-013 SHALL have port stream_valid_o  output  1  stream word available.
REQ-014 SHALL have port stream_ready_i  input  1  sink accepts the stream word.
REQ-015 SHALL have port stream_data_o  output  WORDWIDTH  current stream word.
REQ-016 SHALL have port stream_last_o  output  1  current stream word is index WORDS-1.
REQ-017 SHALL have port results_valid_o  output  1  the buffer holds a captured result set.
REQ-018 SHALL have port overrun_o  output  1  sticky flag; a capture was lost.

Function
REQ-019 SHALL implement states IDLE (no results), HOLD (results held), and STREAM (draining).
REQ-020 SHALL give per-cycle input priority in this order: clr_i, then capture_i, then stream_start_i.
REQ-021 SHALL, on capture_i in IDLE or HOLD, latch all WORDS words from res_i at that edge, then enter HOLD with results_valid_o=1 on the next cycle.
  - A capture in HOLD overwrites the held set without setting overrun.
REQ-022 SHALL, on capture_i in STREAM, ignore the capture: buffer unchanged, overrun_o set to 1 (sticky).
REQ-023 SHALL serve CPU reads in any state with a latency of 1 cycle.
  - en_i=1 at edge N gives data_o = sign-extended buf[addr_i] and rd_valid_o=1 after edge N.
  - data_o holds its value until the next read; rd_valid_o=0 otherwise.
REQ-024 SHALL return the pre-capture buffer value when a read and a capture occur in the same cycle.
REQ-025 SHALL, on stream_start_i in HOLD, enter STREAM with index=0 and stream_valid_o=1 on the next cycle; stream_start_i SHALL be ignored in IDLE and STREAM.
REQ-026 SHALL, in STREAM, drive stream_data_o = buf[index] and stream_last_o = (index==WORDS-1).
  - stream_valid_o stays 1 and stream_data_o stays stable until stream_valid_o && stream_ready_i at an edge.
REQ-027 SHALL, on a transfer with index<WORDS-1, increment the index.
  - Back-to-back transfers sustain one word per cycle.
REQ-028 SHALL, on the transfer of index WORDS-1, return to HOLD with stream_valid_o=0 and stream_last_o=0 on the next cycle; results_valid_o stays 1 so the set can be re-streamed.
REQ-029 SHALL, on clr_i in any state (including mid-stream), take effect at the next edge:
  - state=IDLE, results_valid_o=0, overrun_o=0, stream_valid_o=0, index=0.
  - The buffer contents are retained and remain readable by the CPU.
REQ-030 SHALL NOT let CPU reads disturb the stream index or state.

Reset
REQ-031 SHALL, when rst=0 at a rising edge, set:
  - state=IDLE, all buffer words=0, index=0;
  - data_o=0, rd_valid_o=0, stream_valid_o=0, stream_data_o=0, stream_last_o=0, results_valid_o=0, overrun_o=0.
REQ-032 SHALL give reset priority over every other input, including mid-stream and coincident capture.

Verification
REQ-033 SHALL cover capture then read: res_i word k = 16'h8000+k, capture_i pulse, read addr 3 -> next cycle data_o=32'hFFFF8003, rd_valid_o=1.
REQ-034 SHALL cover a full stream with stream_ready_i held 1: 32 consecutive words 16'h8000..16'h801F, stream_last_o only on the 32nd, then state HOLD and stream_valid_o=0.
REQ-035 SHALL cover backpressure: stream_ready_i=0 for 5 cycles at index 7 -> stream_data_o stays 16'h8007, stream_valid_o=1 throughout, no words skipped.
REQ-036 SHALL cover capture during stream: capture_i with res_i all 16'h1234 at index 10 -> overrun_o=1, remaining stream words unchanged (16'h800A...), a later read of addr 0 returns 32'hFFFF8000.
REQ-037 SHALL cover clr mid-stream then restart: clr_i at index 4 -> stream_valid_o=0 and results_valid_o=0 next cycle; stream_start_i then ignored; a read of addr 4 still returns 32'hFFFF8004.
REQ-038 SHALL cover reset mid-stream: rst=0 at index 12 -> all outputs 0 next cycle, and a read of addr 12 returns 32'h00000000.
